// File: rtl/apb_master_if.sv
// Bundle of signals between an APB master and its two neighbours: the command/response
// side (a local requester) and the APB bus side (a single completer).
//   cmd_*    : command request from the requester (valid/ready handshake)
//   rsp_*    : completion pulse, read data and timeout flag back to the requester
//   xfer_cnt : number of transfers completed with pready
//   p*       : APB bus signals
// Modports:
//   master : the view of the apb_master block itself
//   slave  : the view of everything around it (requester plus APB completer)
interface apb_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [15:0]       xfer_cnt;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, xfer_cnt,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, xfer_cnt,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB master: turns one accepted command into one APB transfer (SETUP then ACCESS),
// waits for pready with a bounded timeout, and reports a one-cycle completion pulse.
// Ports:
//   pclk   : clock, all state on the rising edge
//   preset : asynchronous active-high reset
//   bus    : apb_master_if.master (command, response, transfer count and APB signals)
// Parameters:
//   ADDR_W, DATA_W : APB address / data widths (must match the interface instance)
//   TIMEOUT        : ACCESS cycles without pready before the transfer is aborted (2..255)
module apb_master #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic           pclk,
    input logic           preset,
    apb_master_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    // Value of the wait counter during the last allowed ACCESS cycle.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        wait_q, wait_d;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [15:0]       xfer_q;

    logic accept;
    logic done;
    logic abort;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    wait_d  = 8'd0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (bus.pready) begin
                    // pready wins over a timeout on the same edge
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q == TimeoutLast) begin
                        abort   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= StIdle;
            wait_q      <= 8'd0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            xfer_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            rsp_valid_q <= done | abort;
            if (accept) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
            end
            if (done) begin
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                xfer_q      <= xfer_q + 16'd1;
            end else if (abort) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    // Bus controls decode straight from state so reset drops them without waiting for a clock.
    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.psel      = (state_q != StIdle);
    assign bus.penable   = (state_q == StAccess);
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master (TIMEOUT = 16): a table of single transfers with
// hand-computed results, plus sequences for back-to-back commands and reset mid-transfer.
module tb_apb_master;

    logic pclk;
    logic preset;

    apb_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          nwait;     // ACCESS cycles with pready low before pready rises
        logic        stuck;     // pready never rises
        logic [31:0] prdata;
        int          exp_acc;   // expected number of ACCESS cycles
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v, input int idx);
        int nacc;
        bit got;
        @(negedge pclk);
        chk($sformatf("v%0d_cmd_ready", idx), 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.prdata    = v.prdata;
        bus.pready    = 1'b0;
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~v.wr;
        bus.cmd_addr  = ~v.addr;
        bus.cmd_wdata = ~v.wdata;
        chk($sformatf("v%0d_setup_psel", idx), 64'(bus.psel), 64'd1);
        chk($sformatf("v%0d_setup_penable", idx), 64'(bus.penable), 64'd0);
        chk($sformatf("v%0d_pwrite", idx), 64'(bus.pwrite), 64'(v.wr));
        chk($sformatf("v%0d_paddr", idx), 64'(bus.paddr), 64'(v.addr));
        chk($sformatf("v%0d_pwdata", idx), 64'(bus.pwdata), 64'(v.wdata));
        nacc = 0;
        got  = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge pclk); #1;
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else if (bus.psel && bus.penable) begin
                nacc++;
                chk($sformatf("v%0d_paddr_stable", idx), 64'(bus.paddr), 64'(v.addr));
                bus.pready = !v.stuck && (nacc > v.nwait);
            end
        end
        bus.pready = 1'b0;
        if (!v.exp_err) exp_cnt++;
        chk($sformatf("v%0d_rsp_seen", idx), 64'(got), 64'd1);
        chk($sformatf("v%0d_access_cycles", idx), 64'(nacc), 64'(v.exp_acc));
        chk($sformatf("v%0d_rsp_err", idx), 64'(bus.rsp_err), 64'(v.exp_err));
        chk($sformatf("v%0d_rsp_rdata", idx), 64'(bus.rsp_rdata), 64'(v.exp_rdata));
        chk($sformatf("v%0d_xfer_cnt", idx), 64'(bus.xfer_cnt), 64'(exp_cnt));
        chk($sformatf("v%0d_ready_after", idx), 64'(bus.cmd_ready), 64'd1);
        chk($sformatf("v%0d_psel_idle", idx), 64'(bus.psel), 64'd0);
        @(posedge pclk); #1;
        chk($sformatf("v%0d_rsp_pulse_end", idx), 64'(bus.rsp_valid), 64'd0);
        chk($sformatf("v%0d_rsp_err_hold", idx), 64'(bus.rsp_err), 64'(v.exp_err));
        chk($sformatf("v%0d_rsp_rdata_hold", idx), 64'(bus.rsp_rdata), 64'(v.exp_rdata));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_psel"}, 64'(bus.psel), 64'd0);
        chk({tag, "_penable"}, 64'(bus.penable), 64'd0);
        chk({tag, "_pwrite"}, 64'(bus.pwrite), 64'd0);
        chk({tag, "_paddr"}, 64'(bus.paddr), 64'd0);
        chk({tag, "_pwdata"}, 64'(bus.pwdata), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        chk({tag, "_xfer_cnt"}, 64'(bus.xfer_cnt), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    endtask

    vec_t vecs[6];

    initial begin
        int n_acc;
        int last;
        int viol;
        int pulses;
        int rsp_seen;
        logic prev_psel;

        //           wr    addr   wdata          nw  stk   prdata         acc err  rdata
        vecs[0] = '{1'b1, 8'h04, 32'hDEADBEEF,  0, 1'b0, 32'h11111111,  1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 8'h04, 32'h0,         3, 1'b0, 32'hDEADBEEF,  4, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 8'h10, 32'h0,         0, 1'b1, 32'h5555AAAA, 16, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 8'h80, 32'h0,        15, 1'b0, 32'h12345678, 16, 1'b0, 32'h12345678};
        vecs[4] = '{1'b1, 8'hFF, 32'hA5A5A5A5,  1, 1'b0, 32'h99999999,  2, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 8'h01, 32'h0,         0, 1'b0, 32'hCAFEF00D,  1, 1'b0, 32'hCAFEF00D};

        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 32'h0;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b0;
        #1;
        chk_reset_values("rst");
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;

        for (int i = 0; i < 6; i++) run_xfer(vecs[i], i);

        // Back-to-back: cmd_valid held high, pready tied high.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h20;
        bus.cmd_wdata = 32'h00000100;
        bus.pready    = 1'b1;
        n_acc     = 0;
        last      = -1;
        viol      = 0;
        pulses    = 0;
        prev_psel = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk);
            if (bus.penable && !prev_psel) viol++;
            prev_psel = bus.psel;
            if (bus.rsp_valid) pulses++;
            if (bus.cmd_ready && bus.cmd_valid) begin
                if (last >= 0) chk("b2b_accept_spacing", 64'(c - last), 64'd3);
                last = c;
                n_acc++;
            end
            @(posedge pclk); #1;
            if (n_acc == 3) bus.cmd_valid = 1'b0;
            bus.cmd_wdata = bus.cmd_wdata + 32'd1;
        end
        bus.pready = 1'b0;
        exp_cnt += 3;
        chk("b2b_accepts", 64'(n_acc), 64'd3);
        chk("b2b_rsp_pulses", 64'(pulses), 64'd3);
        chk("b2b_bare_penable", 64'(viol), 64'd0);
        chk("b2b_xfer_cnt", 64'(bus.xfer_cnt), 64'(exp_cnt));

        // Reset asserted in the middle of ACCESS with pready low.
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h33;
        bus.cmd_wdata = 32'h77777777;
        @(posedge pclk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        chk("mid_in_access", 64'(bus.penable), 64'd1);
        #2;
        preset = 1'b1;
        #1;
        chk_reset_values("mid_rst");
        @(negedge pclk);
        preset  = 1'b0;
        exp_cnt = 0;
        #1;
        chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        rsp_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge pclk); #1;
            if (bus.rsp_valid) rsp_seen++;
        end
        chk("post_rst_no_rsp", 64'(rsp_seen), 64'd0);
        chk("post_rst_psel", 64'(bus.psel), 64'd0);

        // Normal operation resumes after reset.
        run_xfer(vecs[5], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL provide parameter DATA_W, default 32, APB data width.
REQ-003 SHALL provide parameter TIMEOUT, default 16, maximum ACCESS cycles without pready before abort (legal range 2..255).
REQ-004 SHALL have port pclk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port preset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  input  ADDR_W  transfer address.
REQ-010 SHALL have port cmd_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data for completed read.
REQ-013 SHALL have port rsp_err  output  1  completion was a timeout abort.
REQ-014 SHALL have port xfer_cnt  output  16  count of transfers completed with pready.
REQ-015 SHALL have APB ports psel, penable, pwrite (output 1), paddr (output ADDR_W), pwdata (output DATA_W), prdata (input DATA_W), pready (input 1).

Function
REQ-016 SHALL implement FSM IDLE, SETUP, ACCESS; reset state IDLE.
REQ-017 SHALL drive cmd_ready = 1 only in IDLE (combinational from state, not from cmd_valid).
REQ-018 SHALL accept a command at a rising edge where cmd_valid && cmd_ready, registering cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, next state SETUP.
REQ-019 SHALL, in SETUP, drive psel=1, penable=0 for exactly one cycle, then go to ACCESS unconditionally.
REQ-020 SHALL, in ACCESS, drive psel=1, penable=1 and hold paddr/pwrite/pwdata stable until exit.
REQ-021 SHALL complete on a rising edge in ACCESS with pready=1: next state IDLE, rsp_valid=1 next cycle, rsp_err=0, rsp_rdata=prdata sampled at that edge for reads, 0 for writes, xfer_cnt incremented.
REQ-022 SHALL count ACCESS cycles with pready=0 in an 8-bit wait counter, cleared on entry to SETUP.
REQ-023 SHALL abort when pready=0 is sampled on the TIMEOUT-th ACCESS cycle: next state IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0, xfer_cnt unchanged.
REQ-024 SHALL give pready=1 priority over timeout on the same edge (normal completion).
REQ-025 SHALL hold rsp_valid high for exactly one cycle per command; rsp_rdata and rsp_err hold their values until the next completion.
REQ-026 SHALL yield minimum transfer latency: accept edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid in cycle N+3 when pready=1; next accept no earlier than edge N+3.
REQ-027 SHALL keep psel=0, penable=0 in IDLE; paddr/pwrite/pwdata retain last values.
REQ-028 SHALL wrap xfer_cnt from 16'hFFFF to 16'h0000.
REQ-029 SHALL ignore cmd_* inputs outside IDLE.

Reset
REQ-030 SHALL on preset=1 immediately (asynchronously) force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, xfer_cnt=0, wait counter=0.
REQ-031 SHALL abandon any transfer in progress on reset with no rsp_valid pulse; cmd_ready=1 in the first cycle after deassertion.

Verification
REQ-032 Write addr 8'h04 data 32'hDEADBEEF, pready tied 1 -> one SETUP then one ACCESS cycle, pwrite=1, rsp_valid pulse, rsp_err=0, xfer_cnt=1.
REQ-033 Read addr 8'h04, slave returns prdata 32'hDEADBEEF with pready low 3 ACCESS cycles -> psel/penable held 4 ACCESS cycles, paddr stable, rsp_rdata=32'hDEADBEEF.
REQ-034 Read with pready stuck 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, xfer_cnt unchanged, cmd_ready=1 next cycle.
REQ-035 cmd_valid held 1 for 3 back-to-back writes, pready=1 -> accepts spaced 3 cycles apart, xfer_cnt=3, no penable without preceding SETUP.
REQ-036 preset asserted mid-ACCESS -> psel/penable fall before next clock edge, no rsp_valid, all outputs at reset values.
